led_matrix_scan: RTL and testbench

Scan controller for the 8x8 RGB LED matrix that displays the Nim board images. Each frame, it snapshots the three colour planes produced by the game FSM. It then time-multiplexes the matrix row by row, serialising each row's 32 bits into a daisy-chained 4x 8-bit shift-register/latch chain (74HC595-style). It sits between the game FSM outputs and the board pins and owns all display timing.

---
 rtl/nim_pkg.sv | 34 +++
 rtl/scan_tick.sv | 37 +++
 rtl/led_matrix_scan.sv | 183 ++++++++++++++++++
 tb/tb_led_matrix_scan.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nim_pkg.sv
// Shared types and constants for the Nim board display path.
package nim_pkg;

    // One colour plane, indexed [row][col].
    typedef logic [0:7][7:0] image_t;

    localparam int unsigned NUM_ROWS = 8;
    localparam int unsigned ROW_BITS = 32;

    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH    = 3'd3,
        DWELL    = 3'd4
    } scan_state_t;

    // Row word as it leaves the shift chain: {anode, R, G, B}. Anodes are
    // always active-high; colour bytes are flipped for cathode-sink drivers.
    function automatic logic [ROW_BITS-1:0] build_row_word(
        input logic [2:0] row,
        input logic [7:0] red,
        input logic [7:0] green,
        input logic [7:0] blue,
        input bit         active_low
    );
        logic [7:0] anode;
        logic [7:0] mask;
        anode = 8'b1 << row;
        mask  = active_low ? 8'hFF : 8'h00;
        return {anode, red ^ mask, green ^ mask, blue ^ mask};
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Loadable down-counter: after a load, strobes o_expire for one cycle on the
// N-th cycle (counting the first cycle after the load edge as cycle 1).
module scan_tick #(
    parameter int unsigned N = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_expire
);

    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(N - 1);

    logic [W-1:0] r_cnt;
    logic         r_armed;

    // Count down from N-1; a load always wins over the running count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else if (i_load) begin
            r_cnt   <= LOAD_VAL;
            r_armed <= 1'b1;
        end else if (r_armed) begin
            if (r_cnt == '0) begin
                r_armed <= 1'b0;
            end else begin
                r_cnt <= r_cnt - W'(1);
            end
        end
    end

    assign o_expire = r_armed && (r_cnt == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed scan controller for the 8x8 RGB matrix behind a 4x 595 chain.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   LOAD     | 1 cycle: snapshot planes on row 0, build the 32-bit row word
//   SHIFT_LO | CLK_DIV cycles: sh_cp low, present next bit (MSB first) on ds
//   SHIFT_HI | CLK_DIV cycles: sh_cp high, ds held; bit counter steps on exit
//   LATCH    | CLK_DIV cycles: st_cp high, chain contents move to the outputs
//   DWELL    | DWELL_CYCLES cycles: oe_n low, row lit; row advances on exit
module led_matrix_scan
    import nim_pkg::*;
#(
    parameter int unsigned CLK_DIV          = 2,
    parameter int unsigned DWELL_CYCLES     = 1000,
    parameter bit          COLOR_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       newGame,
    input  image_t     image_red,
    input  image_t     image_green,
    input  image_t     image_blue,
    output logic       ds,
    output logic       sh_cp,
    output logic       st_cp,
    output logic       oe_n,
    output logic [2:0] row_idx,
    output logic       frame_done
);

    localparam int unsigned ROW_W = $clog2(NUM_ROWS);
    localparam int unsigned BIT_W = $clog2(ROW_BITS);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);
    localparam logic [BIT_W-1:0] FIRST_BIT = BIT_W'(ROW_BITS - 1);

    scan_state_t         r_state;
    scan_state_t         w_state_nxt;
    logic [BIT_W-1:0]    r_bit;
    logic [BIT_W-1:0]    w_bit_dec;
    logic [ROW_W-1:0]    r_row;
    image_t              r_snap_red;
    image_t              r_snap_green;
    image_t              r_snap_blue;
    logic [ROW_BITS-1:0] r_word;
    logic [ROW_BITS-1:0] w_word;

    logic r_ds;
    logic r_sh_cp;
    logic r_st_cp;
    logic r_oe_n;
    logic w_ds_nxt;
    logic w_sh_cp_nxt;
    logic w_st_cp_nxt;
    logic w_oe_n_nxt;

    logic w_state_chg;
    logic w_div_load;
    logic w_div_exp;
    logic w_dwell_load;
    logic w_dwell_exp;

    // Half-period / latch-pulse timer, reloaded on entry to every CLK_DIV state.
    scan_tick #(
        .N (CLK_DIV)
    ) u_div_tick (
        .i_clk    (clk),
        .i_rst    (newGame),
        .i_load   (w_div_load),
        .o_expire (w_div_exp)
    );

    // Row on-time timer, reloaded on entry to DWELL.
    scan_tick #(
        .N (DWELL_CYCLES)
    ) u_dwell_tick (
        .i_clk    (clk),
        .i_rst    (newGame),
        .i_load   (w_dwell_load),
        .o_expire (w_dwell_exp)
    );

    assign w_bit_dec    = r_bit - BIT_W'(1);
    assign w_state_chg  = (w_state_nxt != r_state);
    assign w_div_load   = w_state_chg && (w_state_nxt inside {SHIFT_LO, SHIFT_HI, LATCH});
    assign w_dwell_load = w_state_chg && (w_state_nxt == DWELL);

    // Row 0 reads the live planes because the snapshot is written on this same edge.
    always_comb begin
        w_word = '0;
        if (r_row == '0) begin
            w_word = build_row_word(r_row, image_red[r_row], image_green[r_row],
                                    image_blue[r_row], COLOR_ACTIVE_LOW);
        end else begin
            w_word = build_row_word(r_row, r_snap_red[r_row], r_snap_green[r_row],
                                    r_snap_blue[r_row], COLOR_ACTIVE_LOW);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge newGame) begin
        if (newGame) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD:     w_state_nxt = SHIFT_LO;
            SHIFT_LO: if (w_div_exp) w_state_nxt = SHIFT_HI;
            SHIFT_HI: if (w_div_exp) w_state_nxt = (r_bit == '0) ? LATCH : SHIFT_LO;
            LATCH:    if (w_div_exp) w_state_nxt = DWELL;
            DWELL:    if (w_dwell_exp) w_state_nxt = LOAD;
            default:  w_state_nxt = LOAD;
        endcase
    end

    // Output decode from the next state, so the pins come straight off flops.
    always_comb begin
        w_sh_cp_nxt = (w_state_nxt == SHIFT_HI);
        w_st_cp_nxt = (w_state_nxt == LATCH);
        w_oe_n_nxt  = (w_state_nxt != DWELL);
        w_ds_nxt    = r_ds;
        if ((w_state_nxt == SHIFT_LO) && (r_state == LOAD)) begin
            w_ds_nxt = w_word[ROW_BITS-1];
        end else if ((w_state_nxt == SHIFT_LO) && (r_state == SHIFT_HI)) begin
            w_ds_nxt = r_word[w_bit_dec];
        end
        frame_done = (r_state == DWELL) && w_dwell_exp && (r_row == LAST_ROW);
    end

    // Pin registers.
    always_ff @(posedge clk or posedge newGame) begin
        if (newGame) begin
            r_ds    <= 1'b0;
            r_sh_cp <= 1'b0;
            r_st_cp <= 1'b0;
            r_oe_n  <= 1'b1;
        end else begin
            r_ds    <= w_ds_nxt;
            r_sh_cp <= w_sh_cp_nxt;
            r_st_cp <= w_st_cp_nxt;
            r_oe_n  <= w_oe_n_nxt;
        end
    end

    // Snapshot, row word, bit and row counters.
    always_ff @(posedge clk or posedge newGame) begin
        if (newGame) begin
            r_row        <= '0;
            r_bit        <= FIRST_BIT;
            r_word       <= '0;
            r_snap_red   <= '0;
            r_snap_green <= '0;
            r_snap_blue  <= '0;
        end else begin
            if (r_state == LOAD) begin
                r_word <= w_word;
                if (r_row == '0) begin
                    r_snap_red   <= image_red;
                    r_snap_green <= image_green;
                    r_snap_blue  <= image_blue;
                end
            end
            // Bit 0 wraps to 31, leaving the counter ready for the next row.
            if ((r_state == SHIFT_HI) && w_div_exp) begin
                r_bit <= w_bit_dec;
            end
            if ((r_state == DWELL) && w_dwell_exp) begin
                r_row <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
            end
        end
    end

    assign ds      = r_ds;
    assign sh_cp   = r_sh_cp;
    assign st_cp   = r_st_cp;
    assign oe_n    = r_oe_n;
    assign row_idx = r_row;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: two instances (active-low and active-high colour)
// scanned with CLK_DIV=1, DWELL_CYCLES=4; rows are rebuilt from the pins.
module tb_led_matrix_scan;
    import nim_pkg::*;

    localparam int CLK_DIV   = 1;
    localparam int DWELL     = 4;
    localparam int ROW_P     = 1 + 64 * CLK_DIV + CLK_DIV + DWELL;
    localparam int FRAME_P   = 8 * ROW_P;
    localparam int LATCH_OFS = 1 + 64 * CLK_DIV;
    localparam int FIRST_SH  = 1 + CLK_DIV;
    localparam int NVEC      = 6;

    typedef struct {
        image_t      red;
        image_t      green;
        image_t      blue;
        bit          chk_en;
        logic [2:0]  chk_row;
        logic [31:0] chk_al;
        logic [31:0] chk_ah;
    } vec_t;

    typedef struct {
        logic [2:0]  row;
        logic [31:0] word;
        bit          has_const;
        logic [31:0] cword;
    } sb_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    image_t img_r, img_g, img_b;
    logic       ds_o [2];
    logic       sh_o [2];
    logic       st_o [2];
    logic       oe_o [2];
    logic       fd_o [2];
    logic [2:0] row_o [2];

    int   total = 0;
    int   bad   = 0;
    int   cyc;
    vec_t vecs [NVEC];
    sb_t  q_al [$];
    sb_t  q_ah [$];

    logic        prev_sh [2];
    logic        prev_st [2];
    logic [31:0] shreg [2];
    int          nbits [2];
    int          oe_cnt [2];
    bit          seen_latch [2];
    int          first_sh [2];
    int          last_fd [2];
    int          blank_err [2] = '{0, 0};
    int          fd_count [2] = '{0, 0};

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    led_matrix_scan #(.CLK_DIV(CLK_DIV), .DWELL_CYCLES(DWELL), .COLOR_ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .newGame(rst), .image_red(img_r), .image_green(img_g), .image_blue(img_b),
        .ds(ds_o[0]), .sh_cp(sh_o[0]), .st_cp(st_o[0]), .oe_n(oe_o[0]),
        .row_idx(row_o[0]), .frame_done(fd_o[0]));

    led_matrix_scan #(.CLK_DIV(CLK_DIV), .DWELL_CYCLES(DWELL), .COLOR_ACTIVE_LOW(1'b0)) dut_ah (
        .clk(clk), .newGame(rst), .image_red(img_r), .image_green(img_g), .image_blue(img_b),
        .ds(ds_o[1]), .sh_cp(sh_o[1]), .st_cp(st_o[1]), .oe_n(oe_o[1]),
        .row_idx(row_o[1]), .frame_done(fd_o[1]));

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=0x%0h want=0x%0h", name, d, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int row, input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b, input bit al);
        logic [7:0] an;
        an      = '0;
        an[row] = 1'b1;
        return al ? {an, ~r, ~g, ~b} : {an, r, g, b};
    endfunction

    task automatic apply_vec(input int k);
        img_r = vecs[k].red;
        img_g = vecs[k].green;
        img_b = vecs[k].blue;
    endtask

    task automatic push_frame(input int k);
        sb_t e;
        for (int r = 0; r < 8; r++) begin
            e.row       = 3'(r);
            e.has_const = vecs[k].chk_en && (vecs[k].chk_row == 3'(r));
            e.word      = exp_word(r, vecs[k].red[r], vecs[k].green[r], vecs[k].blue[r], 1'b1);
            e.cword     = vecs[k].chk_al;
            q_al.push_back(e);
            e.word      = exp_word(r, vecs[k].red[r], vecs[k].green[r], vecs[k].blue[r], 1'b0);
            e.cword     = vecs[k].chk_ah;
            q_ah.push_back(e);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_reset_outs();
        for (int d = 0; d < 2; d++) begin
            check("rst_ds", d, 32'(ds_o[d]), 0);
            check("rst_sh_cp", d, 32'(sh_o[d]), 0);
            check("rst_st_cp", d, 32'(st_o[d]), 0);
            check("rst_oe_n", d, 32'(oe_o[d]), 1);
            check("rst_row_idx", d, 32'(row_o[d]), 0);
            check("rst_frame_done", d, 32'(fd_o[d]), 0);
        end
    endtask

    // Pin monitor: rebuilds each row from ds at sh_cp rises, scores it at st_cp rise.
    initial begin
        sb_t e;
        bit  have;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    prev_sh[d] = 1'b0; prev_st[d] = 1'b0; shreg[d] = '0; nbits[d] = 0;
                    oe_cnt[d] = 0; seen_latch[d] = 1'b0; first_sh[d] = -1; last_fd[d] = -1;
                end
            end else begin
                for (int d = 0; d < 2; d++) begin
                    if (sh_o[d] && !prev_sh[d]) begin
                        shreg[d] = {shreg[d][30:0], ds_o[d]};
                        nbits[d]++;
                        if (first_sh[d] < 0) first_sh[d] = cyc;
                    end
                    if (!oe_o[d]) oe_cnt[d]++;
                    if ((sh_o[d] || st_o[d]) && !oe_o[d]) blank_err[d]++;
                    if (st_o[d] && !prev_st[d]) begin
                        check("latch_phase", d, (cyc - LATCH_OFS) % ROW_P, 0);
                        check("bits_per_row", d, nbits[d], 32);
                        if (seen_latch[d]) check("dwell_len", d, oe_cnt[d], DWELL);
                        have = 1'b0;
                        if (d == 0 && q_al.size() > 0) begin e = q_al.pop_front(); have = 1'b1; end
                        if (d == 1 && q_ah.size() > 0) begin e = q_ah.pop_front(); have = 1'b1; end
                        if (have) begin
                            check("row_word", d, shreg[d], e.word);
                            check("latch_row_idx", d, 32'(row_o[d]), 32'(e.row));
                            if (e.has_const) check("row_word_const", d, shreg[d], e.cword);
                        end else begin
                            total++;
                            bad++;
                            $display("FAIL sb_underflow dut%0d got=latch want=none at cyc=%0d", d, cyc);
                        end
                        nbits[d] = 0;
                        oe_cnt[d] = 0;
                        seen_latch[d] = 1'b1;
                    end
                    if (fd_o[d]) begin
                        check("fd_phase", d, cyc % FRAME_P, FRAME_P - 1);
                        check("fd_row_idx", d, 32'(row_o[d]), 7);
                        check("fd_oe_n", d, 32'(oe_o[d]), 0);
                        if (last_fd[d] >= 0) check("fd_period", d, cyc - last_fd[d], FRAME_P);
                        last_fd[d] = cyc;
                        fd_count[d]++;
                    end
                    prev_sh[d] = sh_o[d];
                    prev_st[d] = st_o[d];
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < NVEC; k++) begin
            vecs[k].red = '0; vecs[k].green = '0; vecs[k].blue = '0;
            vecs[k].chk_en = 1'b1; vecs[k].chk_row = 3'd0; vecs[k].chk_al = '0; vecs[k].chk_ah = '0;
        end
        vecs[0].chk_row = 3'd0; vecs[0].chk_al = 32'h01FF_FFFF; vecs[0].chk_ah = 32'h0100_0000;
        vecs[1].chk_row = 3'd3; vecs[1].chk_al = 32'h08FF_FFFF; vecs[1].chk_ah = 32'h0800_0000;
        vecs[2].red[2] = 8'hCC;
        vecs[2].chk_row = 3'd2; vecs[2].chk_al = 32'h0433_FFFF; vecs[2].chk_ah = 32'h04CC_0000;
        vecs[3].red[7] = 8'hA5; vecs[3].green[7] = 8'h3C; vecs[3].blue[7] = 8'h0F;
        vecs[3].chk_row = 3'd5; vecs[3].chk_al = 32'h20FF_FFFF; vecs[3].chk_ah = 32'h2000_0000;
        vecs[4] = vecs[3];
        vecs[4].blue[5] = 8'h81;
        vecs[4].chk_row = 3'd5; vecs[4].chk_al = 32'h20FF_FF7E; vecs[4].chk_ah = 32'h2000_0081;
        for (int r = 0; r < 8; r++) begin
            vecs[5].red[r]   = 8'($urandom);
            vecs[5].green[r] = 8'($urandom);
            vecs[5].blue[r]  = 8'($urandom);
        end
        vecs[5].chk_en = 1'b0;

        apply_vec(0);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outs();
        push_frame(0);
        @(negedge clk);
        rst = 1'b0;

        // New planes land while the previous frame is shifting row 3.
        for (int k = 1; k < NVEC; k++) begin
            wait_until(FRAME_P * (k - 1) + 3 * ROW_P + 21);
            if (k == 1) for (int d = 0; d < 2; d++) check("first_sh_rise", d, first_sh[d], FIRST_SH);
            apply_vec(k);
            push_frame(k);
        end
        wait_until(FRAME_P * (NVEC - 1) + 3 * ROW_P + 21);
        push_frame(NVEC - 1);

        // Reset in the sh_cp-high half of bit 17 of row 4.
        wait_until(FRAME_P * NVEC + 4 * ROW_P + 1 + 2 * CLK_DIV * (31 - 17) + CLK_DIV);
        for (int d = 0; d < 2; d++) begin
            check("pre_rst_sh_cp", d, 32'(sh_o[d]), 1);
            check("pre_rst_row_idx", d, 32'(row_o[d]), 4);
        end
        #1 rst = 1'b1;
        #1 check_reset_outs();
        q_al.delete();
        q_ah.delete();
        apply_vec(2);
        push_frame(2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_until(FRAME_P + 40);

        for (int d = 0; d < 2; d++) begin
            check("restart_first_sh", d, first_sh[d], FIRST_SH);
            check("sb_drained", d, (d == 0) ? q_al.size() : q_ah.size(), 0);
            check("blanking", d, blank_err[d], 0);
            check("fd_count", d, fd_count[d], NVEC + 1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
